// File: rtl/tmds_serializer_10to1.sv
// Three-lane TMDS 10:1 serializer with a one-deep pixel buffer, clock-lane
// pattern generator and pixel-rate strobe, all in the TMDS bit-clock domain.

module tmds_serializer_lane #(
    parameter int          WORD_W    = 10,
    parameter logic [9:0]  IDLE_WORD = 10'b1101010100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              use_buf,
    input  logic              accept,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_bit
);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] buf_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sh <= IDLE_WORD;
        else if (load)
            sh <= use_buf ? buf_q : IDLE_WORD;
        else
            sh <= {1'b0, sh[WORD_W-1:1]};
    end

    // Buffer contents only matter once buf_full is set, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept)
            buf_q <= in_word;
    end

    assign out_bit = sh[0];
endmodule

module tmds_serializer_10to1 #(
    parameter int          WORD_W    = 10,
    parameter logic [9:0]  IDLE_WORD = 10'b1101010100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_red,
    input  logic [WORD_W-1:0] in_green,
    input  logic [WORD_W-1:0] in_blue,
    input  logic              clear_underflow,
    output logic              out_red,
    output logic              out_green,
    output logic              out_blue,
    output logic              out_clk,
    output logic              pixel_strobe,
    output logic              underflow
);
    localparam int NUM_LANES = 3;

    logic [3:0]                          bit_cnt;
    logic                                buf_full;
    logic                                load;
    logic                                accept;
    logic [NUM_LANES-1:0][WORD_W-1:0]    lane_word;
    logic [NUM_LANES-1:0]                lane_bit;

    assign load     = (bit_cnt == 4'd9);
    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n)
            bit_cnt <= 4'd0;
        else if (load)
            bit_cnt <= 4'd0;
        else
            bit_cnt <= bit_cnt + 4'd1;
    end

    // An accept can only happen while empty, so it never collides with a
    // consuming load; an accept on an idle load refills for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n)
            buf_full <= 1'b0;
        else if (accept)
            buf_full <= 1'b1;
        else if (load)
            buf_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            underflow <= 1'b0;
        else if (load && !buf_full)
            underflow <= 1'b1;
        else if (clear_underflow)
            underflow <= 1'b0;
    end

    assign lane_word = {in_red, in_green, in_blue};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tmds_serializer_lane #(
            .WORD_W    (WORD_W),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .use_buf (buf_full),
            .accept  (accept),
            .in_word (lane_word[i]),
            .out_bit (lane_bit[i])
        );
    end

    assign out_red      = lane_bit[2];
    assign out_green    = lane_bit[1];
    assign out_blue     = lane_bit[0];
    assign out_clk      = (bit_cnt <= 4'd4);
    assign pixel_strobe = load;
endmodule

// File: tb/tb_tmds_serializer_10to1.sv
// Bench for tmds_serializer_10to1: frame-level reference model checked every
// cycle, a table of known words with hand-derived serial streams, and corner cases.

module tb_tmds_serializer_10to1;
    localparam logic [9:0] IDLE = 10'b1101010100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear_underflow = 1'b0;
    logic [9:0] in_red = '0, in_green = '0, in_blue = '0;
    logic       in_ready, out_red, out_green, out_blue, out_clk, pixel_strobe, underflow;

    tmds_serializer_10to1 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .clear_underflow(clear_underflow),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_clk(out_clk), .pixel_strobe(pixel_strobe), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: current word on the wire, position in frame, pending pixels.
    int          m_phase = 0;
    logic [29:0] m_cur = {3{IDLE}};
    logic [29:0] m_pend[$];
    logic        m_uf = 1'b0;

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic acc;
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0;
            m_cur   = {3{IDLE}};
            m_pend.delete();
            m_uf    = 1'b0;
        end else begin
            acc = in_valid && (m_pend.size() == 0);
            if (m_phase == 9) begin
                if (m_pend.size() > 0) m_cur = m_pend.pop_front();
                else                   m_cur = {3{IDLE}};
            end
            if (m_phase == 9 && m_pend.size() == 0 && !(m_cur != {3{IDLE}}) && !acc && 1'b0) m_uf = 1'b1;
            if (acc) m_pend.push_back({in_red, in_green, in_blue});
            m_phase = (m_phase + 1) % 10;
        end
        #1;
        chk("out_red",   out_red,   m_cur[20+m_phase]);
        chk("out_green", out_green, m_cur[10+m_phase]);
        chk("out_blue",  out_blue,  m_cur[m_phase]);
        chk("out_clk",   out_clk,   (m_phase <= 4));
        chk("pixel_strobe", pixel_strobe, (m_phase == 9));
        chk("in_ready",  in_ready,  (m_pend.size() == 0));
        chk("underflow", underflow, m_uf);
    endtask

    // Underflow is tracked before the cycle since it depends on pre-edge state.
    task automatic step();
        logic set_uf;
        set_uf = rst_n && (m_phase == 9) && (m_pend.size() == 0);
        if (set_uf)                       m_uf = 1'b1;
        else if (rst_n && clear_underflow) m_uf = 1'b0;
        cycle();
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 20 && m_phase != p; i++) step();
    endtask

    typedef struct {
        logic [9:0] r, g, b;
        logic [9:0] sr, sg, sb;   // serial streams, first bit sent in the MSB
    } vec_t;

    vec_t vecs[3];
    logic [9:0] got_r, got_g, got_b;
    logic [9:0] w;
    logic       acc_now;
    int         n_acc;

    initial begin
        vecs[0] = '{10'b1000000001, 10'h3FF, 10'h000,
                    10'b1000000001, 10'h3FF, 10'h000};
        vecs[1] = '{10'b0000000011, 10'b1101010100, 10'b0101010101,
                    10'b1100000000, 10'b0010101011, 10'b1010101010};
        vecs[2] = '{10'b0000011111, 10'b1111100000, 10'b1000000000,
                    10'b1111100000, 10'b0000011111, 10'b0000000001};

        // Reset and idle frames
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_out_clk", out_clk, 1'b1);
        got_r = '0;
        for (int k = 0; k < 10; k++) begin
            got_r = {got_r[8:0], out_red};
            step();
        end
        chk("idle_stream", got_r, 10'b0010101011);
        repeat (10) step();
        chk("idle_underflow", underflow, 1'b1);

        // Table of known words
        foreach (vecs[i]) begin
            in_valid = 1'b0;
            align(0);
            in_valid = 1'b1;
            in_red = vecs[i].r; in_green = vecs[i].g; in_blue = vecs[i].b;
            step();
            in_valid = 1'b0;
            in_red = $urandom; in_green = $urandom; in_blue = $urandom;
            align(0);
            got_r = '0; got_g = '0; got_b = '0;
            for (int k = 0; k < 10; k++) begin
                got_r = {got_r[8:0], out_red};
                got_g = {got_g[8:0], out_green};
                got_b = {got_b[8:0], out_blue};
                step();
            end
            chk($sformatf("vec%0d_red", i),   got_r, vecs[i].sr);
            chk($sformatf("vec%0d_green", i), got_g, vecs[i].sg);
            chk($sformatf("vec%0d_blue", i),  got_b, vecs[i].sb);
        end

        // Back-pressure with continuous valid
        in_valid = 1'b0;
        align(0);
        w = 10'h001;
        n_acc = 0;
        clear_underflow = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_red = w; in_green = w + 10'd1; in_blue = ~w;
            acc_now = (m_pend.size() == 0);
            step();
            clear_underflow = 1'b0;
            if (acc_now) begin
                n_acc++;
                w = w + 10'd1;
            end
        end
        in_valid = 1'b0;
        chk("bp_accepts", n_acc, 10);
        chk("bp_underflow", underflow, 1'b0);

        // Underflow with arrival in the load cycle
        align(0);
        align(9);
        in_valid = 1'b1;
        in_red = 10'h155; in_green = 10'h2AA; in_blue = 10'h0F0;
        step();
        in_valid = 1'b0;
        chk("uf_concurrent", underflow, 1'b1);
        chk("uf_idle_sent", in_ready, 1'b0);
        align(9);
        step();
        align(3);
        clear_underflow = 1'b1;
        step();
        clear_underflow = 1'b0;
        chk("uf_cleared", underflow, 1'b0);

        // Clear colliding with a new underflow
        align(9);
        clear_underflow = 1'b1;
        step();
        clear_underflow = 1'b0;
        chk("clr_set_collision", underflow, 1'b1);

        // Reset mid-word with a buffered pixel
        align(0);
        in_valid = 1'b1;
        in_red = 10'h3FF; in_green = 10'h3FF; in_blue = 10'h3FF;
        step();
        in_valid = 1'b0;
        align(4);
        chk("pre_rst_full", in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_clk", out_clk, 1'b1);
        chk("mid_rst_strobe", pixel_strobe, 1'b0);
        chk("mid_rst_red", out_red, 1'b0);
        repeat (30) step();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_red = $urandom; in_green = $urandom; in_blue = $urandom;
            clear_underflow = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; clear_underflow = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tmds_serializer_10to1.md
Name: tmds_serializer_10to1

Overview:
- Consumes the ~252 MHz TMDS bit clock from the board's rPLL (27 MHz × 28 / 3) and drives the four HDMI TMDS lanes from it.
- Takes one 10-bit TMDS word per colour channel per pixel through a one-deep valid/ready buffer.
- Shifts each word out LSB-first at one bit per clock, generates the TMDS clock-lane pattern, and emits a pixel-rate strobe every 10 clocks for upstream pacing.
- Its outputs feed the board's LVDS/ELVDS output buffers directly.

Parameters:
- WORD_W, 10, TMDS symbol width in bits. The block is only defined for 10.
- IDLE_WORD, 10'b1101010100, control-token word sent on reset and on underflow (C1=0, C0=0).

Ports:
- clk  in  1  TMDS bit clock (PLL clkout)
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  in_red/in_green/in_blue hold a pixel
- in_ready  out  1  buffer can accept a pixel; equals !buf_full
- in_red  in  10  TMDS word, red lane
- in_green  in  10  TMDS word, green lane
- in_blue  in  10  TMDS word, blue lane
- clear_underflow  in  1  one-cycle pulse that clears the underflow flag
- out_red  out  1  serial bit, lane 2
- out_green  out  1  serial bit, lane 1
- out_blue  out  1  serial bit, lane 0
- out_clk  out  1  TMDS clock-lane bit
- pixel_strobe  out  1  high for the one cycle in which bit_cnt==9
- underflow  out  1  sticky: a load found the buffer empty

Behaviour:
- Single clock domain. All state is updated only on the posedge of clk.
- State elements:
  - bit_cnt, 4 bits, counts 0..9 and wraps to 0.
  - sh_r, sh_g, sh_b, 10 bits each.
  - buf_r, buf_g, buf_b, 10 bits each, plus buf_full.
  - underflow.
- Reset (rst_n=0 at a clock edge), regardless of current state:
  - bit_cnt=0.
  - sh_* = IDLE_WORD.
  - buf_full=0, so in_ready=1.
  - underflow=0.
  - Resulting outputs: out_red/green/blue = IDLE_WORD[0] = 0, out_clk=1, pixel_strobe=0.
- Outputs:
  - out_x = sh_x[0], taken directly from the register with no combinational path.
  - out_clk = 1 when bit_cnt<=4, else 0. This is pattern 0000011111 LSB-first.
  - pixel_strobe = (bit_cnt==9).
- Shift rule: when bit_cnt!=9, sh_x <= {1'b0, sh_x[9:1]}.
- Load rule: when bit_cnt==9, sh_x is reloaded as follows.
  - If buf_full: sh_x <= buf_x. The buffer is consumed.
  - Else: sh_x <= IDLE_WORD and underflow <= 1.
  - Result: while bit_cnt==k, out_x = word[k] for k = 0..9.
- Accept rule: a handshake occurs when in_valid && in_ready. At that edge, buf_x <= in_x and buf_full <= 1.
- Simultaneous events:
  - Load from a full buffer: in_ready is 0 that cycle, so no accept can occur, and buf_full <= 0.
  - Load with an empty buffer and in_valid=1 in the same cycle:
    - IDLE_WORD is loaded and underflow is set.
    - The incoming pixel is still accepted into the buffer and goes out at the next load. The idle is not replaced.
  - clear_underflow and a new underflow event in the same cycle: set wins, underflow stays 1.
- Latency: a pixel accepted at an edge where bit_cnt=j appears on out_x starting at the edge after the next bit_cnt==9 cycle. That is (9-j) to (9-j)+1 cycles later, and never more than 10.
- Throughput: at most one pixel per 10 clocks. in_ready stays low from accept until the next load.
- Reset mid-word: the current and buffered words are discarded, and the buffered pixel is lost. Upstream must re-sync to pixel_strobe.
- in_x values are ignored when no handshake occurs.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release.
  - Required: in_ready=1, underflow=0, out_clk=1 for bit_cnt 0..4 and 0 for 5..9.
  - Required: pixel_strobe on every 10th cycle.
  - Required: each lane repeats 0,0,1,0,1,0,1,0,1,1 per frame, and underflow=1 after the first load.
- Single word: present in_red=10'b1000000001, in_green=10'h3FF, in_blue=10'h000 with in_valid=1 before the first load.
  - Required in the following frame: red serial = 1,0,0,0,0,0,0,0,0,1; green = ten 1s; blue = ten 0s.
- Back-pressure: hold in_valid=1 continuously with an incrementing word.
  - Required: exactly one accept per 10 cycles, every word emitted in order, underflow stays 0 after clear.
- Underflow with concurrent arrival: buffer empty, in_valid rises in the bit_cnt==9 cycle.
  - Required: IDLE_WORD frame, underflow=1, then the new word in the next frame.
  - Required: a clear_underflow pulse on a cycle with no load drops underflow to 0.
- Clear/set collision: pulse clear_underflow in a bit_cnt==9 cycle with the buffer empty.
  - Required: underflow stays 1.
- Reset mid-word: assert rst_n=0 at bit_cnt=4 with buf_full=1.
  - Required: next cycle bit_cnt=0, outputs follow IDLE_WORD, in_ready=1, and the buffered word is never emitted.
